// File: rtl/spmv_core.sv
// spmv_core: FP16 CSR sparse-matrix x dense-vector engine for a fixed 16-row matrix.
// Each streamed non-zero passes LOAD -> MUL -> ADD -> WB, one clock per state.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for a start rising edge; results and done held
//   S_LOAD | capture A, B and element index from the input stream
//   S_MUL  | FP16 product of the captured pair
//   S_ADD  | locate CSR row of the index, add product to that row
//   S_WB   | write the sum back, decide whether the run is complete
module spmv_core (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [15:0]  i_read_data_A,
    input  logic [15:0]  i_read_data_B,
    input  logic [7:0]   count,
    input  logic [135:0] row_ptr,
    output logic         o_done,
    output logic [255:0] o_register
);

    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_WB
    } state_t;

    state_t      r_state;
    logic        r_start_q;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [7:0]  r_idx;
    logic [15:0] r_prod;
    logic [15:0] r_sum;
    logic [3:0]  r_row;
    logic        r_hit;

    logic        w_start_rise;
    logic [3:0]  w_row;
    logic        w_row_hit;
    logic        w_last;

    // Round a normalised significand (hidden bit at [13], guard/round/sticky in [2:0])
    // to nearest-even, then saturate to infinity or flush to signed zero.
    function automatic logic [15:0] fp16_pack(input logic s, input logic signed [7:0] e,
                                              input logic [13:0] sig);
        logic              rnd;
        logic [11:0]       m;
        logic signed [7:0] ee;
        rnd = sig[2] & (sig[3] | sig[1] | sig[0]);
        m   = {1'b0, sig[13:3]} + {11'd0, rnd};
        ee  = m[11] ? (e + 8'sd1) : e;
        if (ee >= 8'sd31)
            fp16_pack = {s, 5'h1F, 10'h000};
        else if (ee <= 8'sd0)
            fp16_pack = {s, 15'h0000};
        else
            fp16_pack = {s, ee[4:0], (m[11] ? m[10:1] : m[9:0])};
    endfunction

    // FP16 multiply; subnormal operands are treated as signed zero.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic              s;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [21:0]       prod;
        logic [13:0]       sig;
        logic signed [7:0] e;
        s      = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
        prod   = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (prod[21]) begin
            sig = {prod[21:9], |prod[8:0]};
            e   = e + 8'sd1;
        end else begin
            sig = {prod[20:8], |prod[7:0]};
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            fp16_mul = QNAN;
        else if (a_inf || b_inf)
            fp16_mul = {s, 5'h1F, 10'h000};
        else if (a_zero || b_zero)
            fp16_mul = {s, 15'h0000};
        else
            fp16_mul = fp16_pack(s, e, sig);
    endfunction

    // FP16 add; exact cancellation yields +0, subnormal operands are treated as signed zero.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [15:0]       x, y;
        logic [4:0]        d, sh;
        logic [13:0]       mx, my, diff, sig;
        logic [27:0]       wide;
        logic [14:0]       sum;
        logic [3:0]        lz;
        logic signed [7:0] e;
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
        // x is the larger magnitude so the aligned difference is never negative
        if (b[14:0] > a[14:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        d    = x[14:10] - y[14:10];
        sh   = (d > 5'd27) ? 5'd27 : d;
        mx   = {1'b1, x[9:0], 3'b000};
        wide = {1'b1, y[9:0], 3'b000, 14'd0} >> sh;
        my   = {wide[27:15], wide[14] | (|wide[13:0])};
        e    = $signed({3'b000, x[14:10]});
        sum  = {1'b0, mx} + {1'b0, my};
        diff = mx - my;
        lz   = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (diff[i]) lz = 4'(13 - i);
        end
        if (x[15] == y[15]) begin
            if (sum[14]) begin
                sig = {sum[14:2], sum[1] | sum[0]};
                e   = e + 8'sd1;
            end else begin
                sig = sum[13:0];
            end
        end else begin
            sig = diff << lz;
            e   = e - $signed({4'b0000, lz});
        end
        if (a_nan || b_nan)
            fp16_add = QNAN;
        else if (a_inf && b_inf && (a[15] != b[15]))
            fp16_add = QNAN;
        else if (a_inf)
            fp16_add = a;
        else if (b_inf)
            fp16_add = b;
        else if (a_zero && b_zero)
            fp16_add = {a[15] & b[15], 15'h0000};
        else if (a_zero)
            fp16_add = b;
        else if (b_zero)
            fp16_add = a;
        else if ((x[15] != y[15]) && (diff == 14'd0))
            fp16_add = 16'h0000;
        else
            fp16_add = fp16_pack(x[15], e, sig);
    endfunction

    assign w_start_rise = i_start & ~r_start_q;

    // Last element reached, or the matrix has no non-zeros at all.
    assign w_last = (row_ptr[135:128] == 8'd0) || (r_idx >= (row_ptr[135:128] - 8'd1));

    // CSR row search: the lowest row whose [ptr[r], ptr[r+1]) range holds the index.
    always_comb begin
        w_row_hit = 1'b0;
        w_row     = 4'd0;
        for (int r = 0; r < 16; r++) begin
            if (!w_row_hit && (row_ptr[8*r +: 8] <= r_idx) && (r_idx < row_ptr[8*(r+1) +: 8])) begin
                w_row_hit = 1'b1;
                w_row     = 4'(r);
            end
        end
    end

    // Start edge detector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_start_q <= 1'b0;
        else
            r_start_q <= i_start;
    end

    // Sequence each non-zero through load, multiply, accumulate and write-back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_prod     <= '0;
            r_sum      <= '0;
            r_row      <= '0;
            r_hit      <= 1'b0;
            o_done     <= 1'b0;
            o_register <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        o_register <= '0;
                        o_done     <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_a     <= i_read_data_A;
                    r_b     <= i_read_data_B;
                    r_idx   <= count;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_prod  <= fp16_mul(r_a, r_b);
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= fp16_add(o_register[16*w_row +: 16], r_prod);
                    r_row   <= w_row;
                    r_hit   <= w_row_hit;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (r_hit)
                        o_register[16*r_row +: 16] <= r_sum;
                    if (w_last) begin
                        o_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_core.sv
// tb_spmv_core: directed runs of spmv_core; expected results queued at run start,
// checked by an independent monitor when o_done rises.
module tb_spmv_core;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [15:0]  i_read_data_A;
    logic [15:0]  i_read_data_B;
    logic [7:0]   count;
    logic [135:0] row_ptr;
    logic         o_done;
    logic [255:0] o_register;

    spmv_core dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_read_data_A (i_read_data_A),
        .i_read_data_B (i_read_data_B),
        .count         (count),
        .row_ptr       (row_ptr),
        .o_done        (o_done),
        .o_register    (o_register)
    );

    typedef struct {
        int           id;
        logic [255:0] regv;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           start_cyc = 0;
    logic [15:0]  vec_a[16];
    logic [15:0]  vec_b[16];
    logic [255:0] e2;
    logic [255:0] e5;
    logic [135:0] rp2;
    logic [135:0] rp5;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input int id, input string what, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL run%0d %s: got %0h required %0h", id, what, act, req);
    endtask

    task automatic load_vec_csr();
        for (int k = 0; k < 16; k++) begin
            vec_a[k] = 16'h4C00;
            vec_b[k] = 16'h4000;
        end
        vec_a[1] = 16'h4200; vec_b[1] = 16'h4700;
        vec_a[9] = 16'h4200; vec_b[9] = 16'h4700;
    endtask

    task automatic load_vec_arith();
        vec_a[0] = 16'h7BFF; vec_b[0] = 16'h4000;
        vec_a[1] = 16'h0001; vec_b[1] = 16'h3C00;
        vec_a[2] = 16'h7C00; vec_b[2] = 16'h0000;
        vec_a[3] = 16'h3C00; vec_b[3] = 16'h3C00;
        vec_a[4] = 16'hBC00; vec_b[4] = 16'h3C00;
        vec_a[5] = 16'h3C01; vec_b[5] = 16'h3C01;
        vec_a[6] = 16'h3C00; vec_b[6] = 16'h3C00;
        vec_a[7] = 16'h1000; vec_b[7] = 16'h3C00;
    endtask

    // One run: raise start, stream n elements on the 4-cycle grid, wait (bounded) for done.
    // abort_at >= 0 asserts reset during that element and returns with reset held.
    task automatic run(input int id, input logic [135:0] rp, input int n, input logic [255:0] exp_reg,
                       input int exp_lat, input bit toggle, input int abort_at);
        exp_t e;
        bit   seen;
        i_start = 1'b0;
        row_ptr = rp;
        @(negedge i_clk);
        if (abort_at < 0) begin
            e.id   = id;
            e.regv = exp_reg;
            e.lat  = exp_lat;
            exp_q.push_back(e);
        end
        start_cyc = cyc;
        i_start   = 1'b1;
        @(negedge i_clk);
        check(id, "start clears done", 256'(o_done), 256'(0));
        check(id, "start clears result", o_register, 256'(0));
        for (int k = 0; k < n; k++) begin
            i_read_data_A = vec_a[k];
            i_read_data_B = vec_b[k];
            count         = 8'(k);
            if (toggle && k == 3) i_start = 1'b0;
            if (toggle && k == 5) i_start = 1'b1;
            if (abort_at == k) begin
                repeat (2) @(negedge i_clk);
                i_rst   = 1'b1;
                i_start = 1'b0;
                return;
            end
            repeat (4) @(negedge i_clk);
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (o_done) seen = 1'b1;
            else @(negedge i_clk);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL run%0d done timeout: o_done=0 after bound, required 1", id);
        end
    endtask

    // Monitor: on each o_done rise, pop the oldest expectation and compare latency and rows.
    initial begin
        exp_t m;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_done && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected done: o_done rose with no run pending");
                end else begin
                    m = exp_q.pop_front();
                    check(m.id, "latency", 256'(cyc - start_cyc), 256'(m.lat));
                    for (int r = 0; r < 16; r++)
                        check(m.id, $sformatf("row%0d", r), 256'(o_register[16*r +: 16]), 256'(m.regv[16*r +: 16]));
                end
            end
            prev = o_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rp2 = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
        rp5 = {{11{8'd8}}, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
        e2 = '0;
        e2[16*1  +: 16] = 16'h5000;
        e2[16*2  +: 16] = 16'h4D40;
        e2[16*4  +: 16] = 16'h5000;
        e2[16*5  +: 16] = 16'h5000;
        e2[16*8  +: 16] = 16'h5600;
        e2[16*12 +: 16] = 16'h5400;
        e2[16*15 +: 16] = 16'h4D40;
        e5 = '0;
        e5[16*0 +: 16] = 16'h7C00;
        e5[16*2 +: 16] = 16'h7E00;
        e5[16*4 +: 16] = 16'h3C02;
        e5[16*5 +: 16] = 16'h3C00;

        i_rst = 1'b1; i_start = 1'b0;
        i_read_data_A = '0; i_read_data_B = '0; count = '0; row_ptr = '0;
        repeat (3) @(negedge i_clk);
        check(0, "reset done", 256'(o_done), 256'(0));
        check(0, "reset result", o_register, 256'(0));
        i_rst = 1'b0;
        @(negedge i_clk);
        check(0, "idle done", 256'(o_done), 256'(0));

        load_vec_csr();
        run(1, rp2, 10, e2, 41, 1'b0, -1);
        repeat (20) @(negedge i_clk);
        check(1, "held start done", 256'(o_done), 256'(1));
        check(1, "held start result", o_register, e2);

        run(2, rp2, 10, e2, 41, 1'b1, -1);

        run(3, 136'd0, 1, 256'd0, 5, 1'b0, -1);

        load_vec_arith();
        run(4, rp5, 8, e5, 33, 1'b0, -1);

        load_vec_csr();
        run(5, rp2, 10, e2, 41, 1'b0, 5);
        @(negedge i_clk);
        check(5, "abort done", 256'(o_done), 256'(0));
        check(5, "abort result", o_register, 256'(0));
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (10) @(negedge i_clk);
        check(5, "post-abort idle done", 256'(o_done), 256'(0));
        check(5, "post-abort idle result", o_register, 256'(0));

        run(6, rp2, 10, e2, 41, 1'b0, -1);
        repeat (3) @(negedge i_clk);

        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL pending runs: %0d still queued, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
